// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts q down to zero, then either reloads from
// the reload register (pulsing tc and counting wraps) or parks in EXPIRED.
module down_counter_timer #(
  parameter int unsigned         WIDTH          = 4,
  parameter logic [WIDTH-1:0]    RELOAD_DEFAULT = {WIDTH{1'b1}},
  parameter int unsigned         WRAP_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              auto_reload,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              running,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COUNT   = 2'b01,
    ST_EXPIRED = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [WIDTH-1:0]    reload_q, reload_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic                tc_q, tc_d;
  logic                running_q, running_d;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    if (v == {WRAP_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(WRAP_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next-state logic: load beats enable; zero is handled as a terminal event, never by underflow.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    wrap_d   = wrap_q;
    tc_d     = 1'b0;

    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      wrap_d   = {WRAP_W{1'b0}};
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_COUNT: begin
          if (!en) begin
            state_d = state_q;
          end else if (q_q != {WIDTH{1'b0}}) begin
            q_d     = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
            state_d = ST_COUNT;
          end else begin
            tc_d = 1'b1;
            if (auto_reload) begin
              q_d     = reload_q;
              wrap_d  = sat_inc(wrap_q);
              state_d = ST_COUNT;
            end else begin
              q_d     = {WIDTH{1'b0}};
              state_d = ST_EXPIRED;
            end
          end
        end
        ST_EXPIRED: begin
          q_d     = {WIDTH{1'b0}};
          state_d = ST_EXPIRED;
        end
        default: begin
          q_d     = reload_q;
          state_d = ST_IDLE;
        end
      endcase
    end

    running_d = (state_d == ST_COUNT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      q_q       <= RELOAD_DEFAULT;
      reload_q  <= RELOAD_DEFAULT;
      wrap_q    <= {WRAP_W{1'b0}};
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      reload_q  <= reload_d;
      wrap_q    <= wrap_d;
      tc_q      <= tc_d;
      running_q <= running_d;
    end
  end

  assign q        = q_q;
  assign tc       = tc_q;
  assign running  = running_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Synchronous loadable down-counter/timer. It is the counting-direction complement of the team's ripple up-counter. With the default reload value and auto-reload on, q steps 15,14,...,0,15, the exact reverse of the up-counter's 0..15 sequence. It adds load, enable, terminal-count pulse and wrap counting, and sits beside the up-counter as the interval/timeout generator in the counter subsystem.

Parameters:
WIDTH, 4, width of count register q, load_val and reload register
RELOAD_DEFAULT, {WIDTH{1'b1}} (15), value of q and reload register after reset
WRAP_W, 8, width of wrap_cnt

Ports:
clk  input  1  sole clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; one decrement per rising edge while high
load  input  1  load strobe; priority over en
load_val  input  WIDTH  value written to q and reload register on load
auto_reload  input  1  1: reload on terminal count; 0: stop (EXPIRED) at terminal count
q  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle terminal-count pulse
running  output  1  high while state==COUNT
wrap_cnt  output  WRAP_W  number of auto-reloads since reset/load, saturates at all-ones

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-high. All outputs registered.
- Reset (highest priority, wins over load/en): q=RELOAD_DEFAULT, reload_reg=RELOAD_DEFAULT, state=IDLE, tc=0, running=0, wrap_cnt=0.
- States:
  - IDLE: loaded/reset, not started.
  - COUNT: counting.
  - EXPIRED: reached 0 with auto_reload=0.
- Priority per edge: reset > load > en.
- load=1 (any state): q<=load_val, reload_reg<=load_val, wrap_cnt<=0, tc<=0, state<=IDLE. en is ignored that edge.
- IDLE or COUNT, en=1, q!=0: q<=q-1, state<=COUNT, tc<=0.
- IDLE or COUNT, en=1, q==0 (terminal), tc<=1 for exactly that edge in both cases:
  - auto_reload=1: q<=reload_reg, wrap_cnt<=wrap_cnt+1 (saturate at 2^WRAP_W-1), state<=COUNT.
  - auto_reload=0: q holds 0, state<=EXPIRED, wrap_cnt unchanged.
- en=0 (no load): q, state and wrap_cnt hold; tc<=0.
- EXPIRED: en ignored, q=0, tc=0, running=0. Exit only via load (to IDLE) or reset.
- Period: auto-reload period is reload_reg+1 enabled edges. Decrement wraps via terminal logic only, never by arithmetic underflow.
- auto_reload is sampled only on terminal edges and may change freely otherwise.
- load_val=0 with auto_reload=1: every enabled edge is terminal. tc stays high continuously while en=1, q stays 0, and wrap_cnt increments each edge.
- tc pulse timing: tc is high in the cycle following the terminal edge. Consecutive terminal edges give back-to-back tc.
- running = (state==COUNT). It deasserts on the edge entering EXPIRED or IDLE.

Test Plan:
- Reset then auto_reload=1, en=1 for 16 edges -> q=14,13,...,0 on edges 1..15. Edge 16: q=15, tc=1 for one cycle, wrap_cnt=1, running=1 from edge 1.
- load=1, load_val=5, auto_reload=0, then en=1 for 7 edges -> q=5 (IDLE), then 4,3,2,1,0. Edge 6: tc=1, state EXPIRED, running=0. Edge 7: q=0, tc=0. Further en has no effect.
- While counting at q=9, assert load=1 and en=1 with load_val=3 on the same edge -> q=3, state IDLE, wrap_cnt=0, no decrement that edge.
- Count from 15 to q=7, drop en for 3 cycles -> q holds 7, tc=0. Re-enable -> q=6 next edge.
- load_val=0, auto_reload=1, en=1 for 300 edges -> q=0 throughout, tc=1 every cycle, wrap_cnt saturates at 255.
- Reset asserted together with load=1 at q=4 mid-count -> q=15, wrap_cnt=0, tc=0, running=0, state IDLE (reset wins).
